// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packer_pkg
//  Description : Shared types and defaults for fifo_word_packer. The MSB/LSB
//                defaults must agree with the upstream generic_fifo item width.
//  Revision    : 1.0 - initial release
// ============================================================================
package packer_pkg;

  localparam int DEF_MSB   = 3;
  localparam int DEF_LSB   = 0;
  localparam int DEF_LANES = 4;

  // Packer occupancy: collecting lanes, or presenting a finished word
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Counter width able to hold the values 0..lanes inclusive
  function automatic int cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_packer
//  Description : Pops LANES narrow items from a generic_fifo read port and
//                packs them, in pop order, into one wide word offered over a
//                valid/ready handshake. Lane 0 occupies the low bits.
//                Optional macro PACKER_FLUSH_EN adds a flush input that closes
//                a partial word early, plus a word_lanes occupancy output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int MSB   = DEF_MSB,
  parameter int LSB   = DEF_LSB,
  parameter int LANES = DEF_LANES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [MSB:LSB]                   fifo_out,
  output logic                             read,
  output logic [(MSB-LSB+1)*LANES-1:0]     word,
  output logic                             word_valid,
`ifdef PACKER_FLUSH_EN
  input  logic                             flush,
  output logic [cnt_w(LANES)-1:0]          word_lanes,
`endif
  input  logic                             word_ready
);

  localparam int W  = MSB - LSB + 1;
  localparam int CW = cnt_w(LANES);
  localparam logic [CW-1:0] c_lanes = CW'(LANES);

  state_e          state_q, state_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   received_q, received_d;
  logic            inflight_q;
  logic [W-1:0]    lanes_q [LANES];
  logic [W-1:0]    lanes_d [LANES];
  logic [CW-1:0]   word_lanes_q, word_lanes_d;
  logic            flush_go;
  logic            pop;

`ifdef PACKER_FLUSH_EN
  // A flush only counts once at least one pop has been issued for this word
  assign flush_go   = flush && (state_q == FILL) && (issued_q != '0);
  assign word_lanes = word_lanes_q;
`else
  assign flush_go   = 1'b0;
`endif

  // Pop whenever an item is available and the word still has unrequested lanes;
  // reset gates the request so nothing is popped in the reset cycle.
  assign pop        = !reset && !fifo_empty && (state_q == FILL) &&
                      (issued_q < c_lanes) && !flush_go;
  assign read       = pop;
  assign word_valid = (state_q == HOLD);

  for (genvar g = 0; g < LANES; g++) begin : g_word
    assign word[g*W +: W] = lanes_q[g];
  end

  // Next-state: count pops, land returning data in the next free lane,
  // close the word on the last lane (or a flush) and reopen it on acceptance.
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    received_d   = received_q;
    lanes_d      = lanes_q;
    word_lanes_d = word_lanes_q;

    if (pop) begin
      issued_d = issued_q + CW'(1);
    end

    // Data popped last cycle is on fifo_out now
    if (inflight_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (received_q == CW'(i)) begin
          lanes_d[i] = fifo_out;
        end
      end
      received_d = received_q + CW'(1);
    end

    case (state_q)
      FILL: begin
        // Flush blocks new pops, so any in-flight item lands on this same edge
        if ((received_d == c_lanes) || flush_go) begin
          state_d      = HOLD;
          word_lanes_d = received_d;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d      = FILL;
          issued_d     = '0;
          received_d   = '0;
          word_lanes_d = '0;
          // Cleared so a later short (flushed) word has zero in unused lanes
          for (int i = 0; i < LANES; i++) begin
            lanes_d[i] = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register; reset also discards any pop still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      issued_q     <= '0;
      received_q   <= '0;
      inflight_q   <= 1'b0;
      word_lanes_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      inflight_q   <= pop;
      word_lanes_q <= word_lanes_d;
      lanes_q      <= lanes_d;
    end
  end

endmodule
`default_nettype wire
